ppu_reg_port: RTL and testbench
===============================

// Module: ppu_reg_port
// PURPOSE
//  Parametrised, clocked successor to the PPU CPU-interface register block. Samples
//  CPU accesses (n_DBE/RS/RnW/DB) into the PCLK domain and emits one write strobe per
//  access. Holds CTRL0/CTRL1 and the shared first/second write toggle. Sources status
//  reads with a VBL flag that clears on read. Sits between the CPU bus pins and the
//  PPU datapath (scroll/address regs, OAM, VRAM port).
// PARAMETERS
//  RS_W        3             register-select width; NUM_REGS = 2**RS_W
//  DW          8             CPU data width
//  DOUBLE_MASK 8'b0110_0000  bit i set: reg i is double-write (uses toggle)
//  STATUS_IDX  2             index of the read-clear status register
//  CTRL0_IDX   0             index of latched CTRL0; CTRL1_IDX 1 likewise
// PORTS
//  PCLK      in   1         PPU clock, rising edge
//  n_RES     in   1         async active-low reset
//  n_DBE     in   1         CPU access enable, active low, asynchronous to PCLK
//  RS        in   RS_W      register select, stable while n_DBE low
//  RnW       in   1         1 = read, 0 = write
//  DB_in     in   DW        CPU write data
//  DB_out    out  DW        CPU read data
//  DB_oe     out  1         drive enable for DB_out
//  STATUS_in in   DW-1      status bits [DW-2:0] supplied by sprite logic
//  VBL_SET   in   1         1-cycle pulse at vblank start
//  wr_stb    out  NUM_REGS  one-hot, 1-cycle write pulse
//  wr_phase  out  1         toggle value qualifying wr_stb (0 first, 1 second)
//  wr_data   out  DW        data qualifying wr_stb
//  rd_stb    out  NUM_REGS  one-hot, 1-cycle read pulse (for R7-style side effects)
//  ctrl0_q   out  DW        CTRL0 contents
//  ctrl1_q   out  DW        CTRL1 contents
//  vbl_flag  out  1         VBL status flag
//  toggle    out  1         current first/second state
// BEHAVIOUR
//  - Reset (n_RES low, async): every output and internal flop is 0, and DB_oe = 0.
//  - Input sync: n_DBE passes a 2-flop synchroniser, then a third flop for edge
//    detection. The rising PCLK after a detected fall is cycle A.
//  - State machine IDLE -> ACCESS -> IDLE:
//    - IDLE->ACCESS on the synced fall. RS/RnW/DB_in are captured at cycle A.
//    - ACCESS->IDLE on the synced rise.
//    - A rise while in IDLE is ignored. At most one access is decoded per low pulse.
//  - Write (cycle A+1):
//    - wr_stb[RS] = 1 for exactly one cycle, with wr_data = captured DB.
//    - wr_phase = toggle as it was before the access.
//    - If DOUBLE_MASK[RS], toggle inverts in the same cycle; otherwise it is unchanged.
//    - RS == CTRL0_IDX / CTRL1_IDX: register loads at A+1 and is visible at A+2.
//  - Read:
//    - rd_stb[RS] pulses at A+1. DB_oe = 1 from A+1 until the synced rise.
//    - DB_out is frozen at A+1 for the whole access.
//    - STATUS_IDX returns {vbl_flag, STATUS_in}. Other indices return 0; their data
//      is muxed externally.
//  - Status read side effect: on the synced rise ending a STATUS_IDX read, vbl_flag
//    and toggle clear.
//  - VBL_SET sets vbl_flag next cycle.
//  - Simultaneous VBL_SET and read-clear in the same cycle: set wins, flag = 1.
//  - A STATUS read that begins while VBL_SET is pulsing returns the pre-set value.
//  - Toggle flip and status clear cannot coincide, because an access is either a
//    read or a write.
//  - A reset asserted mid-access aborts the access: no strobe, DB_oe drops at once.
//    After reset, a still-low n_DBE is NOT decoded; a fresh fall is required.
//  - Minimum supported n_DBE low/high width: 3 PCLK.
// STRUCTURE
//  - Shared package ppu_regs_pkg:
//    - parameter defaults
//    - register index localparams (CTRL0, CTRL1, STATUS, OAMADDR, OAMDATA, SCROLL,
//      ADDR, DATA)
//    - a typedef for access state {IDLE, ACCESS}
//  - One sub-module: ppu_bus_sync (2-flop sync + edge detect on n_DBE, outputs
//    fall/rise pulses and synced level).
//  - The rest (decode, toggle, ctrl regs, status mux) stays flat in ppu_reg_port.
// TESTING
//  1. Reset: n_RES low mid-run -> all outputs 0. Release with n_DBE high -> still 0.
//  2. Write RS=5 0x12, then RS=5 0x34 ->
//     - wr_stb[5] pulses twice.
//     - wr_phase 0 then 1, wr_data 0x12 then 0x34.
//     - toggle ends 0.
//  3. Write RS=0 0x80, hold n_DBE low 20 PCLK -> single wr_stb[0]; ctrl0_q=0x80 at A+2.
//  4. VBL_SET, then write RS=6 (toggle=1), then read RS=2 with STATUS_in=7'h20 ->
//     - DB_out = 0xA0, DB_oe high for the access.
//     - After the rise, vbl_flag=0 and toggle=0.
//  5. VBL_SET in the same cycle as the status-read clear -> vbl_flag stays 1.
//  6. n_RES asserted during a write with n_DBE low -> no wr_stb.
//     Release with n_DBE still low -> no strobe until the next fall.

Source files
------------

// File: rtl/ppu_regs_pkg.sv
// ppu_regs_pkg
//  Shared definitions for the PPU CPU-interface register block.
//  - Parameter defaults for ppu_reg_port (select width, data width, double-write mask).
//  - Register index constants for the eight CPU-visible PPU registers.
//  - Access state type used by the port's decode state machine.

package ppu_regs_pkg;

    // Register indices as seen on RS
    localparam int unsigned REG_CTRL0   = 32'd0;
    localparam int unsigned REG_CTRL1   = 32'd1;
    localparam int unsigned REG_STATUS  = 32'd2;
    localparam int unsigned REG_OAMADDR = 32'd3;
    localparam int unsigned REG_OAMDATA = 32'd4;
    localparam int unsigned REG_SCROLL  = 32'd5;
    localparam int unsigned REG_ADDR    = 32'd6;
    localparam int unsigned REG_DATA    = 32'd7;

    // Parameter defaults
    localparam int unsigned PPU_RS_W = 32'd3;
    localparam int unsigned PPU_DW   = 32'd8;

    // SCROLL and ADDR are the two registers written as first/second byte pairs
    localparam logic [7:0] PPU_DOUBLE_MASK = (8'd1 << REG_SCROLL) | (8'd1 << REG_ADDR);

    // Decode state: waiting for an access, or inside one (n_DBE still low)
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } acc_state_e;

endpackage

// File: rtl/ppu_bus_sync.sv
// ppu_bus_sync
//  Brings the asynchronous CPU access enable n_DBE into the PCLK domain through a
//  two-flop synchroniser, with a third flop holding the previous synchronised level
//  so that falling and rising edges can be detected.
// Ports
//  clk       in   PPU clock, rising edge
//  rst_n     in   async active-low reset (all stages reset to 0)
//  n_dbe     in   raw CPU access enable, active low
//  dbe_fall  out  1-cycle pulse: synchronised n_DBE went 1 -> 0
//  dbe_rise  out  1-cycle pulse: synchronised n_DBE went 0 -> 1
//  dbe_level out  synchronised n_DBE level

module ppu_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic n_dbe,
    output logic dbe_fall,
    output logic dbe_rise,
    output logic dbe_level
);

    // [0],[1] synchroniser stages, [2] previous synchronised level
    logic [2:0] sync_r;

    // Shift n_DBE through the synchroniser and edge-history stages.
    // Resetting to 0 (low level) means a still-low n_DBE after reset produces no
    // fall; a fresh high-then-low sequence is needed to start an access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], n_dbe};
        end
    end

    // Edge pulses decoded from flop outputs only, so they are glitch-free.
    always_comb begin
        dbe_level = sync_r[1];
        dbe_fall  = sync_r[2] & ~sync_r[1];
        dbe_rise  = ~sync_r[2] & sync_r[1];
    end

endmodule

// File: rtl/ppu_reg_port.sv
// ppu_reg_port
//  Clocked CPU-interface register block of the PPU. Each CPU access (n_DBE low pulse)
//  is synchronised into PCLK, decoded once, and turned into a single one-hot write or
//  read strobe. Holds CTRL0/CTRL1, the shared first/second write toggle, and the VBL
//  status flag that clears when a status read completes.
// Ports
//  PCLK, n_RES          clock, async active-low reset
//  n_DBE, RS, RnW       CPU access enable (async), register select, read/not-write
//  DB_in                CPU write data
//  DB_out, DB_oe        CPU read data (frozen per access) and its drive enable
//  STATUS_in, VBL_SET   status bits from sprite logic, vblank-start pulse
//  wr_stb/phase/data    one-hot write pulse with its toggle phase and data
//  rd_stb               one-hot read pulse
//  ctrl0_q, ctrl1_q     latched CTRL0 / CTRL1
//  vbl_flag, toggle     VBL status flag, current first/second write state

module ppu_reg_port
    import ppu_regs_pkg::*;
#(
    parameter int unsigned RS_W       = PPU_RS_W,
    parameter int unsigned DW         = PPU_DW,
    parameter logic [(2**RS_W)-1:0] DOUBLE_MASK = (2**RS_W)'(PPU_DOUBLE_MASK),
    parameter int unsigned STATUS_IDX = REG_STATUS,
    parameter int unsigned CTRL0_IDX  = REG_CTRL0,
    parameter int unsigned CTRL1_IDX  = REG_CTRL1
) (
    input  logic                   PCLK,
    input  logic                   n_RES,
    input  logic                   n_DBE,
    input  logic [RS_W-1:0]        RS,
    input  logic                   RnW,
    input  logic [DW-1:0]          DB_in,
    output logic [DW-1:0]          DB_out,
    output logic                   DB_oe,
    input  logic [DW-2:0]          STATUS_in,
    input  logic                   VBL_SET,
    output logic [(2**RS_W)-1:0]   wr_stb,
    output logic                   wr_phase,
    output logic [DW-1:0]          wr_data,
    output logic [(2**RS_W)-1:0]   rd_stb,
    output logic [DW-1:0]          ctrl0_q,
    output logic [DW-1:0]          ctrl1_q,
    output logic                   vbl_flag,
    output logic                   toggle
);

    localparam int unsigned NUM_REGS = 2**RS_W;
    localparam logic [RS_W-1:0] STATUS_SEL = RS_W'(STATUS_IDX);
    localparam logic [RS_W-1:0] CTRL0_SEL  = RS_W'(CTRL0_IDX);
    localparam logic [RS_W-1:0] CTRL1_SEL  = RS_W'(CTRL1_IDX);
    localparam logic [NUM_REGS-1:0] ONEHOT_BASE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic                 dbe_fall_s;
    logic                 dbe_rise_s;
    logic                 dbe_level_s;
    acc_state_e           state_r;
    logic                 pend_r;       // high for the one cycle between capture and decode
    logic [RS_W-1:0]      cap_rs_r;
    logic                 cap_rnw_r;
    logic [DW-1:0]        cap_data_r;
    logic [NUM_REGS-1:0]  sel_onehot_s;
    logic                 access_end_s;
    logic                 status_clr_s;

    ppu_bus_sync u_sync (
        .clk       (PCLK),
        .rst_n     (n_RES),
        .n_dbe     (n_DBE),
        .dbe_fall  (dbe_fall_s),
        .dbe_rise  (dbe_rise_s),
        .dbe_level (dbe_level_s)
    );

    // Access state machine and capture of RS/RnW/DB_in on the cycle after the fall.
    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            state_r    <= ST_IDLE;
            pend_r     <= 1'b0;
            cap_rs_r   <= {RS_W{1'b0}};
            cap_rnw_r  <= 1'b0;
            cap_data_r <= {DW{1'b0}};
        end else begin
            pend_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A rise seen here is ignored; only a fall opens an access
                    if (dbe_fall_s && !dbe_level_s) begin
                        state_r    <= ST_ACCESS;
                        pend_r     <= 1'b1;
                        cap_rs_r   <= RS;
                        cap_rnw_r  <= RnW;
                        cap_data_r <= DB_in;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dbe_rise_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Decode of the captured select and detection of a completed status read.
    always_comb begin
        sel_onehot_s = ONEHOT_BASE << cap_rs_r;
        access_end_s = 1'b0;
        status_clr_s = 1'b0;
        if ((state_r == ST_ACCESS) && dbe_rise_s) begin
            access_end_s = 1'b1;
            status_clr_s = cap_rnw_r && (cap_rs_r == STATUS_SEL);
        end else begin
            access_end_s = 1'b0;
            status_clr_s = 1'b0;
        end
    end

    // Strobes, toggle, control registers, read data/enable and VBL flag.
    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            wr_stb   <= {NUM_REGS{1'b0}};
            rd_stb   <= {NUM_REGS{1'b0}};
            wr_phase <= 1'b0;
            wr_data  <= {DW{1'b0}};
            DB_out   <= {DW{1'b0}};
            DB_oe    <= 1'b0;
            ctrl0_q  <= {DW{1'b0}};
            ctrl1_q  <= {DW{1'b0}};
            vbl_flag <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            wr_stb <= {NUM_REGS{1'b0}};
            rd_stb <= {NUM_REGS{1'b0}};

            // Set has priority over a read-clear landing in the same cycle
            if (VBL_SET) begin
                vbl_flag <= 1'b1;
            end else if (status_clr_s) begin
                vbl_flag <= 1'b0;
            end else begin
                vbl_flag <= vbl_flag;
            end

            if (pend_r) begin
                if (cap_rnw_r) begin
                    rd_stb <= sel_onehot_s;
                    DB_oe  <= 1'b1;
                    // vbl_flag here is the pre-update value, so a read racing
                    // VBL_SET reports the flag as it was before the set
                    if (cap_rs_r == STATUS_SEL) begin
                        DB_out <= {vbl_flag, STATUS_in};
                    end else begin
                        DB_out <= {DW{1'b0}};
                    end
                end else begin
                    wr_stb   <= sel_onehot_s;
                    wr_phase <= toggle;
                    wr_data  <= cap_data_r;
                    if (DOUBLE_MASK[cap_rs_r]) begin
                        toggle <= ~toggle;
                    end else begin
                        toggle <= toggle;
                    end
                    if (cap_rs_r == CTRL0_SEL) begin
                        ctrl0_q <= cap_data_r;
                    end else begin
                        ctrl0_q <= ctrl0_q;
                    end
                    if (cap_rs_r == CTRL1_SEL) begin
                        ctrl1_q <= cap_data_r;
                    end else begin
                        ctrl1_q <= ctrl1_q;
                    end
                end
            end else if (access_end_s) begin
                DB_oe <= 1'b0;
                // A completed status read also rewinds the write pair toggle
                if (status_clr_s) begin
                    toggle <= 1'b0;
                end else begin
                    toggle <= toggle;
                end
            end else begin
                DB_oe  <= DB_oe;
                toggle <= toggle;
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_port.sv
// tb_ppu_reg_port
//  Directed and randomised accesses on the CPU pins of ppu_reg_port, checked against
//  a transaction-level model (toggle, VBL flag, CTRL0/CTRL1) kept in the bench.

module tb_ppu_reg_port;

    logic       PCLK = 1'b0;
    logic       n_RES = 1'b0;
    logic       n_DBE = 1'b1;
    logic [2:0] RS = 3'd0;
    logic       RnW = 1'b1;
    logic [7:0] DB_in = 8'h00;
    logic [7:0] DB_out;
    logic       DB_oe;
    logic [6:0] STATUS_in = 7'h00;
    logic       VBL_SET = 1'b0;
    logic [7:0] wr_stb;
    logic       wr_phase;
    logic [7:0] wr_data;
    logic [7:0] rd_stb;
    logic [7:0] ctrl0_q;
    logic [7:0] ctrl1_q;
    logic       vbl_flag;
    logic       toggle;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model state
    bit       m_toggle = 1'b0;
    bit       m_vbl    = 1'b0;
    bit [7:0] m_ctrl0  = 8'h00;
    bit [7:0] m_ctrl1  = 8'h00;

    ppu_reg_port dut (
        .PCLK      (PCLK),
        .n_RES     (n_RES),
        .n_DBE     (n_DBE),
        .RS        (RS),
        .RnW       (RnW),
        .DB_in     (DB_in),
        .DB_out    (DB_out),
        .DB_oe     (DB_oe),
        .STATUS_in (STATUS_in),
        .VBL_SET   (VBL_SET),
        .wr_stb    (wr_stb),
        .wr_phase  (wr_phase),
        .wr_data   (wr_data),
        .rd_stb    (rd_stb),
        .ctrl0_q   (ctrl0_q),
        .ctrl1_q   (ctrl1_q),
        .vbl_flag  (vbl_flag),
        .toggle    (toggle)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".toggle"}, 32'(toggle), 32'(m_toggle));
        chk({tag, ".vbl"},    32'(vbl_flag), 32'(m_vbl));
        chk({tag, ".ctrl0"},  32'(ctrl0_q), 32'(m_ctrl0));
        chk({tag, ".ctrl1"},  32'(ctrl1_q), 32'(m_ctrl1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wr_stb"},   32'(wr_stb), 32'h0);
        chk({tag, ".rd_stb"},   32'(rd_stb), 32'h0);
        chk({tag, ".wr_phase"}, 32'(wr_phase), 32'h0);
        chk({tag, ".wr_data"},  32'(wr_data), 32'h0);
        chk({tag, ".DB_out"},   32'(DB_out), 32'h0);
        chk({tag, ".DB_oe"},    32'(DB_oe), 32'h0);
        chk({tag, ".ctrl0"},    32'(ctrl0_q), 32'h0);
        chk({tag, ".ctrl1"},    32'(ctrl1_q), 32'h0);
        chk({tag, ".vbl"},      32'(vbl_flag), 32'h0);
        chk({tag, ".toggle"},   32'(toggle), 32'h0);
    endtask

    task automatic model_reset();
        m_toggle = 1'b0;
        m_vbl    = 1'b0;
        m_ctrl0  = 8'h00;
        m_ctrl1  = 8'h00;
    endtask

    task automatic vbl_pulse(input string tag);
        @(negedge PCLK);
        VBL_SET = 1'b1;
        @(negedge PCLK);
        VBL_SET = 1'b0;
        m_vbl = 1'b1;
        chk({tag, ".vbl_set"}, 32'(vbl_flag), 32'h1);
    endtask

    // One complete CPU access: n_DBE low for 'low' PCLK, then high. Strobes are
    // expected on the 4th rising edge after the fall (2 sync + capture + decode),
    // DB_oe until 3 edges after the rise, when the status side effect also lands.
    // vbl_clash drives VBL_SET into that same edge.
    task automatic do_access(input string tag, input int rs, input bit rnw,
                             input logic [7:0] data, input logic [6:0] st,
                             input int low, input bit vbl_clash);
        logic [7:0] onehot;
        logic [7:0] exp_dout;
        logic [7:0] wr_val, rd_val, wd, c0_at5, c1_at5;
        bit         ph, exp_oe;
        int         wr_cnt, rd_cnt, wr_first, rd_first, oe_bad, dout_bad;
        onehot   = 8'd1 << rs;
        exp_dout = (rs == 2) ? {m_vbl, st} : 8'h00;
        wr_cnt = 0; rd_cnt = 0; wr_first = 0; rd_first = 0; oe_bad = 0; dout_bad = 0;
        wr_val = 8'h00; rd_val = 8'h00; wd = 8'h00; ph = 1'b0; c0_at5 = 8'h00; c1_at5 = 8'h00;

        @(negedge PCLK);
        RS = 3'(rs); RnW = rnw; DB_in = data; STATUS_in = st; n_DBE = 1'b0;
        for (int c = 1; c <= low + 5; c++) begin
            @(posedge PCLK);
            #1;
            if (wr_stb != 8'h00) begin
                wr_cnt++;
                if (wr_cnt == 1) begin
                    wr_first = c; wr_val = wr_stb; ph = wr_phase; wd = wr_data;
                end
            end
            if (rd_stb != 8'h00) begin
                rd_cnt++;
                if (rd_cnt == 1) begin
                    rd_first = c; rd_val = rd_stb;
                end
            end
            exp_oe = rnw && (c >= 4) && (c <= low + 2);
            if (DB_oe !== exp_oe) oe_bad++;
            if (exp_oe && (DB_out !== exp_dout)) dout_bad++;
            if (c == 5) begin
                c0_at5 = ctrl0_q; c1_at5 = ctrl1_q;
            end
            @(negedge PCLK);
            if (c == low) n_DBE = 1'b1;
            VBL_SET = vbl_clash && (c == low + 2);
        end

        // Update the model with the effects of this access
        if (!rnw) begin
            if (rs == 0) m_ctrl0 = data;
            if (rs == 1) m_ctrl1 = data;
        end
        if (rnw) begin
            chk({tag, ".rd_cnt"},   32'(rd_cnt), 32'd1);
            chk({tag, ".rd_first"}, 32'(rd_first), 32'd4);
            chk({tag, ".rd_stb"},   32'(rd_val), 32'(onehot));
            chk({tag, ".wr_cnt"},   32'(wr_cnt), 32'd0);
            chk({tag, ".dout_bad"}, 32'(dout_bad), 32'd0);
            if (rs == 2) begin
                m_vbl    = 1'b0;
                m_toggle = 1'b0;
            end
        end else begin
            chk({tag, ".wr_cnt"},   32'(wr_cnt), 32'd1);
            chk({tag, ".wr_first"}, 32'(wr_first), 32'd4);
            chk({tag, ".wr_stb"},   32'(wr_val), 32'(onehot));
            chk({tag, ".wr_phase"}, 32'(ph), 32'(m_toggle));
            chk({tag, ".wr_data"},  32'(wd), 32'(data));
            chk({tag, ".rd_cnt"},   32'(rd_cnt), 32'd0);
            if (rs == 5 || rs == 6) m_toggle = ~m_toggle;
        end
        if (vbl_clash) m_vbl = 1'b1;
        chk({tag, ".oe_bad"},   32'(oe_bad), 32'd0);
        chk({tag, ".ctrl0_a2"}, 32'(c0_at5), 32'(m_ctrl0));
        chk({tag, ".ctrl1_a2"}, 32'(c1_at5), 32'(m_ctrl1));
        check_state(tag);
    endtask

    initial begin
        int wr_seen;

        // 1. Power-on reset, then release with n_DBE high
        repeat (3) @(posedge PCLK);
        #1;
        check_zero("reset");
        @(negedge PCLK);
        n_RES = 1'b1;
        repeat (6) @(posedge PCLK);
        #1;
        check_zero("post_reset");

        // 2. Double write to SCROLL: phase 0 then 1, toggle back to 0
        do_access("scroll_w1", 5, 1'b0, 8'h12, 7'h00, 4, 1'b0);
        do_access("scroll_w2", 5, 1'b0, 8'h34, 7'h00, 4, 1'b0);
        chk("scroll.toggle_end", 32'(toggle), 32'h0);

        // 3. CTRL0 write with a long low pulse: still a single strobe
        do_access("ctrl0_long", 0, 1'b0, 8'h80, 7'h00, 20, 1'b0);

        // 4. VBL, ADDR first write, then status read returns 0xA0 and clears
        vbl_pulse("t4");
        do_access("addr_w1", 6, 1'b0, 8'h21, 7'h00, 3, 1'b0);
        chk("addr_w1.toggle_set", 32'(toggle), 32'h1);
        do_access("status_rd", 2, 1'b1, 8'h00, 7'h20, 5, 1'b0);
        chk("status_rd.vbl_clr", 32'(vbl_flag), 32'h0);

        // 5. VBL_SET coinciding with the status read clear: flag stays set
        do_access("status_clash", 2, 1'b1, 8'h00, 7'h55, 4, 1'b1);

        // 1b. Reset asserted mid-run clears everything at once
        @(negedge PCLK);
        n_RES = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge PCLK);
        n_RES = 1'b1;
        repeat (5) @(posedge PCLK);

        // 6. Reset during a write with n_DBE low: no strobe, even after release
        @(negedge PCLK);
        RS = 3'd0; RnW = 1'b0; DB_in = 8'h55; n_DBE = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        n_RES = 1'b0;
        #1;
        chk("abort.DB_oe", 32'(DB_oe), 32'h0);
        chk("abort.wr_stb", 32'(wr_stb), 32'h0);
        wr_seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge PCLK);
            #1;
            if (wr_stb != 8'h00) wr_seen++;
            @(negedge PCLK);
            if (c == 2) n_RES = 1'b1;
        end
        chk("abort.no_strobe", 32'(wr_seen), 32'd0);
        check_state("abort");
        @(negedge PCLK);
        n_DBE = 1'b1;
        repeat (5) @(posedge PCLK);
        do_access("after_abort", 1, 1'b0, 8'h3C, 7'h00, 3, 1'b0);

        // Randomised accesses with occasional VBL pulses between them
        for (int i = 0; i < 40; i++) begin
            int rs, low;
            bit rnw;
            logic [7:0] d;
            logic [6:0] st;
            rs  = int'($urandom_range(0, 7));
            rnw = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            st  = 7'($urandom);
            low = int'($urandom_range(3, 8));
            if ($urandom_range(0, 3) == 0) vbl_pulse("rnd");
            do_access("rnd", rs, rnw, d, st, low, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
